instr_fetch_unit: RTL

//   Program-counter and fetch stage that sits directly upstream of the instruction memory.

---
 rtl/instr_fetch_unit.sv | 96 +++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// PC and fetch stage feeding an IF/ID register with a valid/ready handshake.
// Define IFETCH_WRAP_EN to wrap past end of memory instead of halting.
module instr_fetch_unit #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rd,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              id_ready,
    output logic              id_valid,
    output logic [DATA_W-1:0] id_instr,
    output logic [ADDR_W-1:0] id_pc,
    output logic [ADDR_W-1:0] id_pc_plus4,
    output logic              halted
);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_e;

    localparam logic [ADDR_W-1:0] FOUR    = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] LAST_PC = {{(ADDR_W-2){1'b1}}, 2'b00};

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0] idpc_q, idpc_d;
    logic [ADDR_W-1:0] p4_q, p4_d;
    logic              fire;

    assign fire = (state_q == S_RUN) && !redirect_valid
                  && (!valid_q || id_ready);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        instr_d = instr_q;
        idpc_d  = idpc_q;
        p4_d    = p4_q;
        if (redirect_valid) begin
            // Wrong-path slot is dropped even under back-pressure
            pc_d    = {redirect_pc[ADDR_W-1:2], 2'b00};
            valid_d = 1'b0;
            state_d = S_RUN;
        end else begin
            if (state_q == S_BOOT) state_d = S_RUN;
            if (fire) begin
                instr_d = imem_rd;
                idpc_d  = pc_q;
                p4_d    = pc_q + FOUR;
                valid_d = 1'b1;
                pc_d    = pc_q + FOUR;
`ifndef IFETCH_WRAP_EN
                if (pc_q == LAST_PC) state_d = S_HALT;
`endif
            end else if (valid_q && id_ready) begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_BOOT;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            instr_q <= '0;
            idpc_q  <= '0;
            p4_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            idpc_q  <= idpc_d;
            p4_q    <= p4_d;
        end
    end

    assign imem_addr   = pc_q;
    assign id_valid    = valid_q;
    assign id_instr    = instr_q;
    assign id_pc       = idpc_q;
    assign id_pc_plus4 = p4_q;
    assign halted      = (state_q == S_HALT);

endmodule
